// File: rtl/mc_control_fsm.sv
// Multicycle RV32 control unit: sequences fetch/decode/execute/memory/writeback
// and drives datapath mux selects, write enables and the ALU function code.
module mc_control_fsm #(
  parameter bit LUI_EN      = 1'b1,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_t     state, next_state;
  logic       ready;
  logic       op_legal;
  logic [1:0] alu_op;
  logic       pcw_s, mw_s, irw_s, rw_s, done_s, ill_s;

  // Handshake: mem_ready is sampled only in FETCH/MEMREAD/MEMWRITE; those states
  // keep their request asserted and stay put until the cycle mem_ready is high.
  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: op_legal = 1'b1;
      OP_LUI:                                   op_legal = LUI_EN;
      default:                                  op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:    next_state = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          OP_LUI:       next_state = LUI_EN ? S_LUI : S_FETCH;
          default:      next_state = S_FETCH;
        endcase
      end
      // op[5] separates sw (0100011) from lw (0000011)
      S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      S_BEQ:      next_state = S_FETCH;
      S_LUI:      next_state = S_ALUWB;
      default:    next_state = S_FETCH;
    endcase
  end

  always_comb begin
    pcw_s      = 1'b0;
    mw_s       = 1'b0;
    irw_s      = 1'b0;
    rw_s       = 1'b0;
    done_s     = 1'b0;
    ill_s      = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    alu_op     = 2'b00;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw_s     = ready;
        pcw_s     = ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ill_s   = ~op_legal;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw_s      = 1'b1;
        done_s    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mw_s   = 1'b1;
        done_s = ready;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB: begin
        rw_s   = 1'b1;
        done_s = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pcw_s   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        pcw_s   = Zero;
        done_s  = 1'b1;
      end
      S_LUI:      ALUSrcB = 2'b01;
      default: ;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    if (state == S_LUI) begin
      ALUControl = 3'b100;
    end else begin
      case (alu_op)
        2'b01: ALUControl = 3'b001;
        2'b10: begin
          case (funct3)
            3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
            3'b010:  ALUControl = 3'b101;
            3'b110:  ALUControl = 3'b011;
            3'b111:  ALUControl = 3'b010;
            default: ALUControl = 3'b000;
          endcase
        end
        default: ALUControl = 3'b000;
      endcase
    end
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 3'b001;
      OP_BEQ:  ImmSrc = 3'b010;
      OP_JAL:  ImmSrc = 3'b011;
      OP_LUI:  ImmSrc = 3'b100;
      default: ImmSrc = 3'b000;
    endcase
  end

  // Strobes are qualified by rst_n so an asserted reset kills them in the same cycle.
  assign PCWrite       = pcw_s  & rst_n;
  assign MemWrite      = mw_s   & rst_n;
  assign IRWrite       = irw_s  & rst_n;
  assign RegWrite      = rw_s   & rst_n;
  assign instr_done    = done_s & rst_n;
  assign illegal_instr = ill_s  & rst_n;

endmodule
